// File: rtl/vec_store_unit.sv
// Strided vector store: buffers one vector register on request and streams its
// active elements to memory as single-element writes at base + k*stride.
module vec_store_unit #(
  parameter int VLEN = 64,
  parameter int ELEN = 32,
  parameter int AW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ELEN-1:0]          req_data [0:VLEN-1],
  input  logic [AW-1:0]            req_base,
  input  logic [AW-1:0]            req_stride,
  input  logic [$clog2(VLEN):0]    req_vl,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [ELEN-1:0]          mem_wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int IW   = $clog2(VLEN) + 1;
  localparam int IDXW = (VLEN > 1) ? $clog2(VLEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   len_q, len_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   stride_q, stride_d;
  logic [ELEN-1:0] data_q [0:VLEN-1];
  logic            load;
  logic [IW-1:0]   vl_clip;

  assign vl_clip = (req_vl > IW'(VLEN)) ? IW'(VLEN) : req_vl;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          load     = 1'b1;
          len_d    = vl_clip;
          addr_d   = req_base;
          stride_d = req_stride;
          idx_d    = '0;
          state_d  = (vl_clip == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (mem_ready) begin
          idx_d  = idx_q + IW'(1);
          addr_d = addr_q + stride_q;  // wraps modulo 2^AW by width
          if (idx_q == len_q - IW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  // NOTE: the vector buffer is deliberately not reset; it is only read in SEND,
  // which can only be reached after a fresh load, so stale contents are dead.
  always_ff @(posedge clk) begin
    if (load) data_q <= req_data;
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = (state_q == SEND);
  assign busy      = (state_q == SEND) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = (state_q == SEND) ? data_q[idx_q[IDXW-1:0]] : '0;

endmodule

// File: tb/tb_vec_store_unit.sv
// Directed self-checking bench for vec_store_unit: unit/negative stride, backpressure,
// length edges, reset mid-transfer and request hold-off.
module tb_vec_store_unit;

  localparam int VLEN = 64;
  localparam int ELEN = 32;
  localparam int AW   = 32;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [ELEN-1:0] req_data [0:VLEN-1];
  logic [AW-1:0]   req_base;
  logic [AW-1:0]   req_stride;
  logic [6:0]      req_vl;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_addr;
  logic [ELEN-1:0] mem_wdata;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  vec_store_unit #(.VLEN(VLEN), .ELEN(ELEN), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_vl     (req_vl),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_data();
    for (int i = 0; i < VLEN; i++) req_data[i] = '0;
  endtask

  task automatic set_req(input logic [6:0] vl, input logic [AW-1:0] base, input logic [AW-1:0] stride);
    req_valid  = 1'b1;
    req_vl     = vl;
    req_base   = base;
    req_stride = stride;
  endtask

  task automatic expect_beat(input string tag, input logic [AW-1:0] addr, input logic [ELEN-1:0] data);
    check({tag, "_valid"}, 64'(mem_valid), 64'd1);
    check({tag, "_addr"},  64'(mem_addr),  64'(addr));
    check({tag, "_data"},  64'(mem_wdata), 64'(data));
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_vl     = '0;
    req_base   = '0;
    req_stride = '0;
    mem_ready  = 1'b0;
    clear_data();
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_mvalid", 64'(mem_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // mem_ready pulse while idle is ignored
    mem_ready = 1'b1;
    tick();
    check("idle_rdy_mvalid", 64'(mem_valid), 64'd0);
    check("idle_rdy_ready", 64'(req_ready), 64'd1);

    // Unit stride, vl=4
    req_data[0] = 32'h11; req_data[1] = 32'h22; req_data[2] = 32'h33; req_data[3] = 32'h44;
    req_data[4] = 32'h55;
    set_req(7'd4, 32'h100, 32'd4);
    tick();
    req_valid = 1'b0;
    check("us_busy", 64'(busy), 64'd1);
    check("us_ready", 64'(req_ready), 64'd0);
    expect_beat("us_b0", 32'h100, 32'h11); tick();
    expect_beat("us_b1", 32'h104, 32'h22); tick();
    expect_beat("us_b2", 32'h108, 32'h33); tick();
    expect_beat("us_b3", 32'h10C, 32'h44); tick();
    check("us_done", 64'(done), 64'd1);
    check("us_done_mvalid", 64'(mem_valid), 64'd0);
    check("us_done_busy", 64'(busy), 64'd1);
    tick();
    check("us_done_pulse", 64'(done), 64'd0);
    check("us_idle_ready", 64'(req_ready), 64'd1);
    check("us_idle_busy", 64'(busy), 64'd0);

    // Backpressure, vl=2
    clear_data();
    req_data[0] = 32'hA0; req_data[1] = 32'hB0;
    mem_ready = 1'b0;
    set_req(7'd2, 32'h200, 32'h10);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_beat("bp_stall", 32'h200, 32'hA0);
      tick();
    end
    mem_ready = 1'b1;
    expect_beat("bp_b0", 32'h200, 32'hA0); tick();
    expect_beat("bp_b1", 32'h210, 32'hB0); tick();
    check("bp_done", 64'(done), 64'd1);
    tick();

    // Negative stride with address wrap
    clear_data();
    req_data[0] = 32'hC0; req_data[1] = 32'hC1; req_data[2] = 32'hC2;
    set_req(7'd3, 32'h4, 32'hFFFF_FFF8);
    tick();
    req_valid = 1'b0;
    expect_beat("ns_b0", 32'h0000_0004, 32'hC0); tick();
    expect_beat("ns_b1", 32'hFFFF_FFFC, 32'hC1); tick();
    expect_beat("ns_b2", 32'hFFFF_FFF4, 32'hC2); tick();
    check("ns_done", 64'(done), 64'd1);
    tick();

    // vl=0: straight to DONE, no writes
    set_req(7'd0, 32'h700, 32'd4);
    tick();
    req_valid = 1'b0;
    check("vl0_mvalid", 64'(mem_valid), 64'd0);
    check("vl0_done", 64'(done), 64'd1);
    tick();
    check("vl0_done_pulse", 64'(done), 64'd0);
    check("vl0_mvalid2", 64'(mem_valid), 64'd0);
    check("vl0_ready", 64'(req_ready), 64'd1);

    // vl=100 clipped to 64 beats
    begin
      int beats;
      bit seen_done;
      beats = 0;
      seen_done = 1'b0;
      for (int i = 0; i < VLEN; i++) req_data[i] = 32'(i * 3 + 1);
      set_req(7'd100, 32'h1000, 32'd8);
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
        if (done) seen_done = 1'b1;
        else begin
          if (mem_valid) begin
            check("v100_addr", 64'(mem_addr), 64'(32'h1000 + 32'(beats) * 32'd8));
            check("v100_data", 64'(mem_wdata), 64'(beats * 3 + 1));
            beats++;
          end
          tick();
        end
      end
      check("v100_done_seen", 64'(seen_done), 64'd1);
      check("v100_beats", 64'(beats), 64'd64);
      tick();
    end

    // Reset in the middle of an 8-element transfer
    clear_data();
    for (int i = 0; i < 8; i++) req_data[i] = 32'hD0 + 32'(i);
    set_req(7'd8, 32'h300, 32'd4);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    expect_beat("rm_b4", 32'h310, 32'hD4);
    #1;
    rst_n = 1'b0;
    #1;
    check("rm_mvalid", 64'(mem_valid), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    check("rm_done", 64'(done), 64'd0);
    check("rm_ready", 64'(req_ready), 64'd1);
    check("rm_addr", 64'(mem_addr), 64'd0);
    check("rm_wdata", 64'(mem_wdata), 64'd0);
    begin
      int done_hits;
      done_hits = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (done || mem_valid) done_hits++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (done || mem_valid) done_hits++;
      end
      check("rm_quiet_after", 64'(done_hits), 64'd0);
    end
    clear_data();
    req_data[0] = 32'h77;
    set_req(7'd1, 32'h400, 32'd4);
    tick();
    req_valid = 1'b0;
    expect_beat("rm_new_b0", 32'h400, 32'h77); tick();
    check("rm_new_done", 64'(done), 64'd1);
    tick();

    // Hold-off with req_valid held high; inputs change after the first accept
    clear_data();
    req_data[0] = 32'h1; req_data[1] = 32'h2;
    set_req(7'd2, 32'h500, 32'd4);
    tick();
    req_data[0] = 32'h99; req_data[1] = 32'h98;
    req_vl = 7'd1; req_base = 32'h600; req_stride = 32'd16;
    check("ho_ready_send", 64'(req_ready), 64'd0);
    expect_beat("ho_r1_b0", 32'h500, 32'h1); tick();
    check("ho_ready_send2", 64'(req_ready), 64'd0);
    expect_beat("ho_r1_b1", 32'h504, 32'h2); tick();
    check("ho_done1", 64'(done), 64'd1);
    check("ho_ready_done", 64'(req_ready), 64'd0);
    tick();
    check("ho_idle_ready", 64'(req_ready), 64'd1);
    check("ho_idle_mvalid", 64'(mem_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    expect_beat("ho_r2_b0", 32'h600, 32'h99); tick();
    check("ho_done2", 64'(done), 64'd1);
    tick();
    check("ho_final_idle", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
